// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_CNT_W = 16;
  localparam int ZERO_ADDR = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_sb_busy_vec.sv
// Per-register busy bits: clear on writeback, set on issue, set wins.
module sb_busy_vec
  import regfile_sb_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] nxt;
  logic             set_ok;

  assign set_ok = set_en &&
    !(ZERO_REG && set_addr == AW'(ZERO_ADDR));

  always_comb begin
    nxt = busy;
    if (clr_en) nxt[clr_addr] = 1'b0;
    if (set_ok) nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with same-cycle write bypass and a RAW busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = DEF_CNT_W,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic             use_a,
  input  logic             use_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             hazard,
  output logic [DEPTH-1:0] busy,
  output logic [CNT_W-1:0] wr_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             zero_a;
  logic             zero_b;
  logic             byp_a;
  logic             byp_b;

  assign wr_ok  = wr_en &&
    !(ZERO_REG && wr_addr == AW'(ZERO_ADDR));
  assign zero_a = ZERO_REG && rs == AW'(ZERO_ADDR);
  assign zero_b = ZERO_REG && rt == AW'(ZERO_ADDR);
  assign byp_a  = wr_en && wr_addr == rs;
  assign byp_b  = wr_en && wr_addr == rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_count <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1'b1;
    end
  end

  always_comb begin
    A = mem[rs];
    if (zero_a)     A = '0;
    else if (byp_a) A = wr_data;
  end

  always_comb begin
    B = mem[rt];
    if (zero_b)     B = '0;
    else if (byp_b) B = wr_data;
  end

  sb_busy_vec #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .set_en   (issue_en),
    .set_addr (issue_addr),
    .busy     (busy)
  );

  // A producer completing this cycle is covered by the bypass.
  assign hazard = (use_a && busy[rs] && !byp_a) ||
                  (use_b && busy[rt] && !byp_b);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of the register file, bypass and scoreboard.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, wr_addr, issue_addr;
  logic        use_a, use_b, wr_en, issue_en;
  logic [31:0] a, b, wr_data;
  logic        hazard;
  logic [31:0] busy;
  logic [15:0] wr_count;

  logic [2:0]  p_rs, p_rt, p_wr_addr, p_issue_addr;
  logic        p_use_a, p_use_b, p_wr_en, p_issue_en;
  logic [15:0] p_a, p_b, p_wr_data;
  logic        p_hazard;
  logic [7:0]  p_busy;
  logic [3:0]  p_wr_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk        (clk),
    .rst        (rst),
    .rs         (rs),
    .rt         (rt),
    .use_a      (use_a),
    .use_b      (use_b),
    .A          (a),
    .B          (b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .hazard     (hazard),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  regfile_sb #(
    .WIDTH    (16),
    .DEPTH    (8),
    .ZERO_REG (1'b0),
    .CNT_W    (4)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .rs         (p_rs),
    .rt         (p_rt),
    .use_a      (p_use_a),
    .use_b      (p_use_b),
    .A          (p_a),
    .B          (p_b),
    .wr_en      (p_wr_en),
    .wr_addr    (p_wr_addr),
    .wr_data    (p_wr_data),
    .issue_en   (p_issue_en),
    .issue_addr (p_issue_addr),
    .hazard     (p_hazard),
    .busy       (p_busy),
    .wr_count   (p_wr_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs = '0; rt = '0; use_a = 1'b0; use_b = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0;
    p_rs = '0; p_rt = '0; p_use_a = 1'b0; p_use_b = 1'b0;
    p_wr_en = 1'b0; p_wr_addr = '0; p_wr_data = '0;
    p_issue_en = 1'b0; p_issue_addr = '0;
    tick();
    rst = 1'b0;

    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    tick();
    wr_en = 1'b0; rs = 5'd3; #1;
    chk("pre_rst_a", a, 32'd7);
    chk("pre_rst_cnt", wr_count, 16'd1);

    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    rst = 1'b0; wr_en = 1'b0; issue_en = 1'b0; #1;
    chk("rst_a", a, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_cnt", wr_count, 16'd0);

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rs = 5'd5; #1;
    chk("wr5_a", a, 32'hDEADBEEF);
    chk("wr5_cnt", wr_count, 16'd1);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    rs = 5'd0; #1;
    chk("r0_byp", a, 32'd0);
    tick();
    wr_en = 1'b0; #1;
    chk("r0_a", a, 32'd0);
    chk("r0_cnt", wr_count, 16'd1);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    rs = 5'd9; rt = 5'd9; #1;
    chk("byp_a", a, 32'h55);
    chk("byp_b", b, 32'h55);
    tick();
    wr_en = 1'b0; #1;
    chk("post_byp_b", b, 32'h55);
    chk("post_byp_cnt", wr_count, 16'd2);

    issue_en = 1'b1; issue_addr = 5'd4;
    tick();
    issue_en = 1'b0; #1;
    chk("busy4_set", busy[4], 1'b1);
    rs = 5'd4; rt = 5'd9; use_a = 1'b1; #1;
    chk("haz_a", hazard, 1'b1);
    use_a = 1'b0; #1;
    chk("haz_noa", hazard, 1'b0);
    rt = 5'd4; use_b = 1'b1; #1;
    chk("haz_b", hazard, 1'b1);
    use_a = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; #1;
    chk("haz_wb", hazard, 1'b0);
    chk("wb_byp_a", a, 32'h44);
    tick();
    wr_en = 1'b0; #1;
    chk("busy4_clr", busy[4], 1'b0);
    chk("haz_after", hazard, 1'b0);
    use_a = 1'b0; use_b = 1'b0;

    issue_en = 1'b1; issue_addr = 5'd6;
    tick();
    chk("busy6_set", busy[6], 1'b1);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    tick();
    wr_en = 1'b0; issue_en = 1'b0; rs = 5'd6; use_a = 1'b1; #1;
    chk("busy6_keep", busy[6], 1'b1);
    chk("reg6", a, 32'h66);
    chk("haz6", hazard, 1'b1);
    chk("cnt6", wr_count, 16'd4);

    issue_en = 1'b1; issue_addr = 5'd0;
    tick();
    issue_en = 1'b0; rs = 5'd0; #1;
    chk("busy0_never", busy[0], 1'b0);
    chk("haz0", hazard, 1'b0);
    use_a = 1'b0;

    p_wr_en = 1'b1; p_wr_addr = 3'd0; p_wr_data = 16'hABCD;
    p_issue_en = 1'b1; p_issue_addr = 3'd0;
    tick();
    p_wr_en = 1'b0; p_issue_en = 1'b0; #1;
    chk("p_r0", p_a, 16'hABCD);
    chk("p_busy0", p_busy[0], 1'b1);
    chk("p_cnt1", p_wr_count, 4'd1);
    p_use_a = 1'b1; #1;
    chk("p_haz0", p_hazard, 1'b1);
    p_use_a = 1'b0;

    for (int i = 0; i < 15; i++) begin
      p_wr_en = 1'b1;
      p_wr_addr = 3'(i + 1);
      p_wr_data = 16'(i);
      tick();
      if (i == 13) chk("p_cnt15", p_wr_count, 4'd15);
    end
    p_wr_en = 1'b0; #1;
    chk("p_wrap", p_wr_count, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
